// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS two-master bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int MIPS_AW = 32;
    localparam int MIPS_DW = 32;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Combinational owner selector; tie rule is round-robin when ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with master 1 (data) winning.
module mips_bus_arb_pick
    import mips_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output arb_state_t next_state
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

    always_comb begin
        next_state = IDLE;
        case (req)
            2'b01:   next_state = GNT0;
            2'b10:   next_state = GNT1;
`ifdef ARB_ROUND_ROBIN_EN
            // The master that was not served last gets the bus.
            2'b11:   next_state = last_served ? GNT0 : GNT1;
`else
            2'b11:   next_state = GNT1;
`endif
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-style bus arbiter (m0 = instruction fetch, m1 = data).
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is m1 priority.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int AW = MIPS_AW,
    parameter int DW = MIPS_DW
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW/8-1:0] m0_byteenable,
    input  logic [DW-1:0]   m0_writedata,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_waitrequest,

    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW/8-1:0] m1_byteenable,
    input  logic [DW-1:0]   m1_writedata,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_waitrequest,

    output logic [AW-1:0]   s_address,
    output logic            s_read,
    output logic            s_write,
    output logic [DW/8-1:0] s_byteenable,
    output logic [DW-1:0]   s_writedata,
    input  logic [DW-1:0]   s_readdata,
    input  logic            s_waitrequest,

    output logic [1:0]      grant,
    output logic            busy
);

    arb_state_t state;
    arb_state_t pick_state;
    logic       req0, req1;
    logic [1:0] pick_req;
    logic       last_served;
    logic       complete;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign complete = ~s_waitrequest &
                      (((state == GNT0) & req0) | ((state == GNT1) & req1));

    // On completion the owner's own strobe is masked so it cannot win again
    // on the same edge; a re-request is picked up from IDLE next cycle.
    always_comb begin
        pick_req = {req1, req0};
        case (state)
            GNT0:    pick_req = {req1, 1'b0};
            GNT1:    pick_req = {1'b0, req0};
            default: pick_req = {req1, req0};
        endcase
    end

    mips_bus_arb_pick u_pick (
        .req         (pick_req),
        .last_served (last_served),
        .next_state  (pick_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= pick_state;
                GNT0: begin
                    if (!req0)              state <= IDLE;
                    else if (!s_waitrequest) state <= pick_state;
                end
                GNT1: begin
                    if (!req1)              state <= IDLE;
                    else if (!s_waitrequest) state <= pick_state;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        last_served <= 1'b0;
        else if (complete) last_served <= (state == GNT1);
    end
`else
    assign last_served = 1'b0;
    logic unused_complete;
    assign unused_complete = complete;
`endif

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_byteenable   = '0;
        s_writedata    = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = GNT_NONE;
        case (state)
            GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_readdata    = s_readdata;
                m0_waitrequest = s_waitrequest;
                grant          = GNT_M0;
            end
            GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_readdata    = s_readdata;
                m1_waitrequest = s_waitrequest;
                grant          = GNT_M1;
            end
            default: ;
        endcase
    end

    assign busy = |grant;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level ownership model.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [1:0]  grant;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: who owns the bus, who was served last, completions.
    int m_owner = -1;
    bit m_last  = 1'b0;
    int mc0 = 0, mc1 = 0;
    int obs0 = 0, obs1 = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .busy(busy)
    );

    function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
        return m_last ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    function automatic logic [1:0] exp_grant();
        return (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    endfunction

    // Advance one clock edge, stepping the model from the pre-edge inputs.
    task automatic tick();
        int nxt;
        bit r0, r1, rx, ro;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (grant == 2'b01 && r0 && !s_waitrequest) obs0++;
        if (grant == 2'b10 && r1 && !s_waitrequest) obs1++;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = tie_winner();
            else if (r1)   nxt = 1;
            else if (r0)   nxt = 0;
            else           nxt = -1;
        end else begin
            rx = (m_owner == 0) ? r0 : r1;
            ro = (m_owner == 0) ? r1 : r0;
            if (!rx) nxt = -1;
            else if (!s_waitrequest) begin
                if (m_owner == 0) mc0++; else mc1++;
                m_last = m_owner[0];
                nxt = ro ? 1 - m_owner : -1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = nxt;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_byteenable = '0; m0_writedata = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_byteenable = '0; m1_writedata = '0;
        s_readdata = '0; s_waitrequest = 1'b1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_owner = -1;
        m_last  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        m0_read = 1'b1;
        m0_address = 32'hBFC00000;
        rst_n = 1'b0;
        m_owner = -1;
        m_last = 1'b0;
        #1;
        n_cmp++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_grant: got %b/%b want 00/0", grant, busy);
        end
        n_cmp++;
        if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0 || s_write !== 1'b0
            || m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: wr=%b%b rd=%b wr=%b want wr=11 strobes 0",
                               m0_waitrequest, m1_waitrequest, s_read, s_write);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL reset_held: got %b want 00", grant);
        end
        rst_n = 1'b1;
        #1;
        tick();
        n_cmp++;
        if (grant !== 2'b01 || s_address !== 32'hBFC00000 || s_read !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_grant: got %b @%h rd=%b want 01 @bfc00000 rd=1",
                               grant, s_address, s_read);
        end
        s_waitrequest = 1'b0;
        #1;
        tick();
        m0_read = 1'b0;
        s_waitrequest = 1'b1;
    endtask

    task automatic test_single_read();
        logic [3:0] seq;
        apply_reset();
        m0_read = 1'b1;
        m0_address = 32'hBFC00004;
        m0_byteenable = 4'hF;
        s_readdata = 32'h8C020004;
        for (int k = 0; k < 4; k++) begin
            s_waitrequest = (k < 3);
            #1;
            seq[3-k] = m0_waitrequest;
            if (k == 3) begin
                n_cmp++;
                if (m0_readdata !== 32'h8C020004) begin
                    n_fail++; $display("FAIL single_readdata: got %h want 8c020004", m0_readdata);
                end
            end
            tick();
        end
        m0_read = 1'b0;
        s_waitrequest = 1'b1;
        #1;
        n_cmp++;
        if (seq !== 4'b1110) begin
            n_fail++; $display("FAIL single_wait_seq: got %b want 1110", seq);
        end
        n_cmp++;
        if (grant !== 2'b00 || mc0 != obs0) begin
            n_fail++; $display("FAIL single_release: grant %b want 00, completions %0d want %0d",
                               grant, obs0, mc0);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        m0_read = 1'b1; m0_address = 32'hBFC00004; m0_byteenable = 4'hF;
        m1_write = 1'b1; m1_address = 32'hBFC00100; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
        s_waitrequest = 1'b0;
        #1;
        tick();
        n_cmp++;
        if (grant !== 2'b10 || s_write !== 1'b1 || s_address !== 32'hBFC00100
            || s_writedata !== 32'hDEADBEEF || s_byteenable !== 4'hF) begin
            n_fail++; $display("FAIL simul_m1_first: grant %b @%h d=%h want 10 @bfc00100 d=deadbeef",
                               grant, s_address, s_writedata);
        end
        n_cmp++;
        if (m0_waitrequest !== 1'b1 || m0_readdata !== 32'h0) begin
            n_fail++; $display("FAIL simul_m0_stalled: wr=%b rd=%h want 1/0", m0_waitrequest, m0_readdata);
        end
        tick();
        m1_write = 1'b0;
        s_readdata = 32'h12345678;
        #1;
        n_cmp++;
        if (grant !== 2'b01 || s_read !== 1'b1 || s_address !== 32'hBFC00004 || m0_readdata !== 32'h12345678) begin
            n_fail++; $display("FAIL simul_handover: grant %b @%h rd=%h want 01 @bfc00004 12345678",
                               grant, s_address, m0_readdata);
        end
        tick();
        m0_read = 1'b0;
        #1;
        n_cmp++;
        if (grant !== exp_grant()) begin
            n_fail++; $display("FAIL simul_idle: grant %b want %b", grant, exp_grant());
        end
    endtask

    task automatic test_alternate();
        int b0, b1;
        logic [1:0] want;
        apply_reset();
        b0 = obs0; b1 = obs1;
        m0_read = 1'b1; m0_address = 32'hBFC00008;
        m1_read = 1'b1; m1_address = 32'h00001000;
        s_waitrequest = 1'b0;
        #1;
        tick();
        for (int k = 0; k < 8; k++) begin
            want = (k % 2 == 0) ? 2'b10 : 2'b01;
            n_cmp++;
            if (grant !== want || grant !== exp_grant()) begin
                n_fail++; $display("FAIL alternate_%0d: grant %b want %b", k, grant, want);
            end
            tick();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        tick();
        n_cmp++;
        if (obs0 - b0 != 4 || obs1 - b1 != 4 || grant !== 2'b00) begin
            n_fail++; $display("FAIL alternate_counts: m0 %0d m1 %0d grant %b want 4 4 00",
                               obs0 - b0, obs1 - b1, grant);
        end
    endtask

    task automatic test_drop();
        int b1;
        apply_reset();
        b1 = obs1;
        m1_write = 1'b1; m1_address = 32'h00002000; m1_writedata = 32'hCAFEF00D;
        s_waitrequest = 1'b1;
        #1;
        tick();
        n_cmp++;
        if (grant !== 2'b10 || s_write !== 1'b1) begin
            n_fail++; $display("FAIL drop_granted: grant %b wr %b want 10 1", grant, s_write);
        end
        m1_write = 1'b0;
        #1;
        tick();
        n_cmp++;
        if (grant !== 2'b00 || s_write !== 1'b0 || obs1 != b1 || grant !== exp_grant()) begin
            n_fail++; $display("FAIL drop_idle: grant %b wr %b completions %0d want 00 0 %0d",
                               grant, s_write, obs1, b1);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        apply_reset();
        m0_read = 1'b1; m0_address = 32'hBFC00010;
        s_waitrequest = 1'b1;
        #1;
        tick();
        tick();
        n_cmp++;
        if (s_read !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: s_read %b want 1", s_read);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (s_read !== 1'b0 || m0_waitrequest !== 1'b1 || grant !== 2'b00) begin
            n_fail++; $display("FAIL midreset_async: rd %b wr %b grant %b want 0 1 00",
                               s_read, m0_waitrequest, grant);
        end
        m_owner = -1; m_last = 1'b0;
        rst_n = 1'b1;
        b0 = obs0;
        #1;
        tick();
        s_waitrequest = 1'b0;
        s_readdata = 32'hA5A55A5A;
        #1;
        n_cmp++;
        if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'hA5A55A5A) begin
            n_fail++; $display("FAIL midreset_recover: wr %b rd %h want 0 a5a55a5a", m0_waitrequest, m0_readdata);
        end
        tick();
        m0_read = 1'b0;
        n_cmp++;
        if (obs0 != b0 + 1) begin
            n_fail++; $display("FAIL midreset_complete: %0d want %0d", obs0, b0 + 1);
        end
    endtask

    task automatic test_random();
        bit d0, d1, r0, r1;
        logic [1:0]  eg;
        logic [69:0] es;
        logic [1:0]  ew;
        logic [31:0] er0, er1;
        apply_reset();
        mc0 = 0; mc1 = 0; obs0 = 0; obs1 = 0;
        for (int c = 0; c < 400; c++) begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (!r0 && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) m0_read = 1'b1; else m0_write = 1'b1;
                m0_address = $urandom; m0_byteenable = 4'($urandom); m0_writedata = $urandom;
            end else if (r0 && $urandom_range(0, 40) == 0) begin
                m0_read = 1'b0; m0_write = 1'b0;
            end
            if (!r1 && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) m1_read = 1'b1; else m1_write = 1'b1;
                m1_address = $urandom; m1_byteenable = 4'($urandom); m1_writedata = $urandom;
            end else if (r1 && $urandom_range(0, 40) == 0) begin
                m1_read = 1'b0; m1_write = 1'b0;
            end
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
            #1;
            eg = exp_grant();
            es = '0; ew = 2'b11; er0 = '0; er1 = '0;
            if (m_owner == 0) begin
                es = {m0_read, m0_write, m0_address, m0_byteenable, m0_writedata};
                ew[0] = s_waitrequest; er0 = s_readdata;
            end else if (m_owner == 1) begin
                es = {m1_read, m1_write, m1_address, m1_byteenable, m1_writedata};
                ew[1] = s_waitrequest; er1 = s_readdata;
            end
            n_cmp++;
            if (grant !== eg || busy !== (eg != 2'b00)) begin
                n_fail++; $display("FAIL rand_grant cyc %0d: got %b/%b want %b", c, grant, busy, eg);
            end
            n_cmp++;
            if ({s_read, s_write, s_address, s_byteenable, s_writedata} !== es) begin
                n_fail++; $display("FAIL rand_slave cyc %0d: got %h want %h", c,
                                   {s_read, s_write, s_address, s_byteenable, s_writedata}, es);
            end
            n_cmp++;
            if ({m1_waitrequest, m0_waitrequest} !== ew || m0_readdata !== er0 || m1_readdata !== er1) begin
                n_fail++; $display("FAIL rand_master cyc %0d: wr %b%b rd %h %h want %b %h %h", c,
                                   m1_waitrequest, m0_waitrequest, m0_readdata, m1_readdata, ew, er0, er1);
            end
            d0 = (m_owner == 0) && (m0_read | m0_write) && !s_waitrequest;
            d1 = (m_owner == 1) && (m1_read | m1_write) && !s_waitrequest;
            tick();
            if (d0) begin m0_read = 1'b0; m0_write = 1'b0; end
            if (d1) begin m1_read = 1'b0; m1_write = 1'b0; end
        end
        n_cmp++;
        if (obs0 != mc0 || obs1 != mc1) begin
            n_fail++; $display("FAIL rand_completions: got %0d/%0d want %0d/%0d", obs0, obs1, mc0, mc1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_alternate();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
